// File: rtl/mult_div_unit_if.sv
// HI/LO multiply-divide unit bus: issue (start/op/operands), read select, status and results.
// The master is the pipeline side; the slave is the unit itself.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel_hi;
  logic        busy;
  logic        busy_real;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, sel_hi,
    input  busy, busy_real, result, hi, lo
  );

  modport slave (
    input  start, op, a, b, sel_hi,
    output busy, busy_real, result, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO unit: MULT/DIV results computed at issue, held in shadows, committed after
// MULT_CYCLES/DIV_CYCLES busy cycles; new issues are dropped while busy (no backpressure queue).
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  mult_div_unit_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     shadow_hi, shadow_lo;
  logic            shadow_ok;

  logic            load, commit, write_hi, write_lo;

  // Signed and unsigned flavours share one datapath; op[0] selects unsigned.
  logic            is_signed;
  logic [63:0]     ext_a, ext_b, product;
  logic            a_neg, b_neg;
  logic [31:0]     a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign is_signed = ~bus.op[0];
  assign ext_a     = {{32{is_signed & bus.a[31]}}, bus.a};
  assign ext_b     = {{32{is_signed & bus.b[31]}}, bus.b};
  assign product   = ext_a * ext_b;

  // Magnitude divide then re-sign: truncates toward zero, remainder follows the dividend,
  // and 0x80000000 / -1 naturally folds back to 0x80000000 with zero remainder.
  assign a_neg = is_signed & bus.a[31];
  assign b_neg = is_signed & bus.b[31];
  assign a_mag = a_neg ? (32'd0 - bus.a) : bus.a;
  assign b_mag = b_neg ? (32'd0 - bus.b) : bus.b;
  assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
  assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    commit     = 1'b0;
    write_hi   = 1'b0;
    write_lo   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load       = 1'b1;
              next_state = RUN;
            end
            OP_MTHI: write_hi = 1'b1;
            OP_MTLO: write_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
      shadow_ok <= 1'b0;
    end else begin
      if (load) begin
        if (bus.op[1]) begin
          shadow_hi <= rem;
          shadow_lo <= quot;
          shadow_ok <= (bus.b != 32'd0);
          count     <= CW'(DIV_CYCLES);
        end else begin
          shadow_hi <= product[63:32];
          shadow_lo <= product[31:0];
          shadow_ok <= 1'b1;
          count     <= CW'(MULT_CYCLES);
        end
      end else if (state == RUN) begin
        count <= count - CW'(1);
      end

      if (commit && shadow_ok) begin
        hi_q <= shadow_hi;
        lo_q <= shadow_lo;
      end
      if (write_hi) hi_q <= bus.a;
      if (write_lo) lo_q <= bus.a;
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.busy_real = bus.busy | (bus.start & ~bus.op[2]);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.result    = bus.sel_hi ? hi_q : lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of MULT/DIV cases plus hand sequences for
// MTHI/MTLO, dropped issues while busy, reset abort and reset-over-start priority.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;

  mult_div_unit_if bus();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cnt;
    issue(3'd4, v.pre_hi, 32'd0);
    issue(3'd5, v.pre_lo, 32'd0);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.a     = v.a;
    bus.b     = v.b;
    #1;
    chk({v.name, " busy_real at issue"}, {31'd0, bus.busy_real}, 32'd1);
    tick();
    bus.start = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      if (cnt == 0) chk({v.name, " lo held while busy"}, bus.lo, v.pre_lo);
      cnt++;
      tick();
    end
    chk({v.name, " busy cycles"}, 32'(cnt), 32'(v.cycles));
    chk({v.name, " hi"}, bus.hi, v.exp_hi);
    chk({v.name, " lo"}, bus.lo, v.exp_lo);
    bus.sel_hi = 1'b1;
    #1;
    chk({v.name, " result hi"}, bus.result, v.exp_hi);
    bus.sel_hi = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{"mult_neg2x3",   3'd0, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{"multu_neg2x3",  3'd1, 32'hFFFFFFFE, 32'd3,        32'h0, 32'h0, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{"mult_m1xm1",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000000, 32'h00000001, 5};
    vecs[3] = '{"multu_maxsq",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[4] = '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[5] = '{"divu_7_2",      3'd3, 32'd7,        32'd2,        32'h0, 32'h0, 32'h00000001, 32'h00000003, 10};
    vecs[6] = '{"div_7_m2",      3'd2, 32'd7,        32'hFFFFFFFE, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{"divu_big_2",    3'd3, 32'hFFFFFFF9, 32'd2,        32'h0, 32'h0, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[8] = '{"div_by_zero",   3'd2, 32'd5,        32'd0,        32'h11, 32'h22, 32'h00000011, 32'h00000022, 10};
    vecs[9] = '{"div_ovf",       3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h11, 32'h22, 32'h00000000, 32'h80000000, 10};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'd7;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.sel_hi = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset result", bus.result, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // MTHI/MTLO in IDLE: immediate write, never busy.
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678;
    #1;
    chk("mthi busy_real", {31'd0, bus.busy_real}, 32'd0);
    tick();
    bus.start = 1'b0;
    chk("mthi hi", bus.hi, 32'h12345678);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    issue(3'd5, 32'h9ABCDEF0, 32'd0);
    chk("mtlo lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo hi kept", bus.hi, 32'h12345678);
    bus.sel_hi = 1'b1;
    #1;
    chk("result sel hi", bus.result, 32'h12345678);
    bus.sel_hi = 1'b0;
    #1;
    chk("result sel lo", bus.result, 32'h9ABCDEF0);

    // Reserved ops change nothing.
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    issue(3'd7, 32'hDEADBEEF, 32'd1);
    chk("noop hi", bus.hi, 32'h12345678);
    chk("noop lo", bus.lo, 32'h9ABCDEF0);
    chk("noop busy", {31'd0, bus.busy}, 32'd0);

    // Issues during busy are dropped; only the MULT commits.
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEADBEEF;
    #1;
    chk("ign busy_real c1", {31'd0, bus.busy_real}, 32'd1);
    tick();
    chk("ign mtlo lo", bus.lo, 32'h9ABCDEF0);
    bus.op = 3'd2; bus.a = 32'd7; bus.b = 32'd2;
    tick();
    bus.start = 1'b0;
    cnt = 2;
    while (bus.busy === 1'b1 && cnt < 40) begin
      chk("ign busy_real run", {31'd0, bus.busy_real}, 32'd1);
      cnt++;
      tick();
    end
    chk("ign busy cycles", 32'(cnt), 32'd5);
    chk("ign hi", bus.hi, 32'hFFFFFFFF);
    chk("ign lo", bus.lo, 32'hFFFFFFFA);
    chk("ign busy_real after", {31'd0, bus.busy_real}, 32'd0);
    tick();
    chk("ign no div commit", bus.busy, 1'b0);

    // Reset aborts an in-flight DIV.
    issue(3'd3, 32'd7, 32'd2);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort late hi", bus.hi, 32'd0);
    chk("abort late lo", bus.lo, 32'd0);

    // Reset wins over a same-cycle start.
    reset = 1'b1;
    issue(3'd4, 32'hCAFEF00D, 32'd0);
    reset = 1'b0;
    chk("reset prio hi", bus.hi, 32'd0);
    chk("reset prio busy", {31'd0, bus.busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
